mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Three-way round-robin arbiter and access sequencer for the single 16-bit-address / 8-bit-data memory port. Requesters: 0 = CPU control unit (fetch/operand), 1 = DMA engine, 2 = debug port. Each transaction is registered on grant, driven to memory for a fixed number of wait states, and completed with a one-cycle `ack` to the winner. The block sits between the requesters and the memory, and is the only driver of the memory strobes.

## Interface
- `WAIT_STATES`, default 1: extra cycles the memory strobe is held beyond the first (legal 0..7).
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state and outputs immediately.
- `req` in 3: per-requester request level; bit i = requester i.
- `req_we` in 3: per-requester write enable (1 = write, 0 = read).
- `req_addr` in 48: flat addresses, requester i at [16i+15:16i].
- `req_wdata` in 24: flat write data, requester i at [8i+7:8i].
- `gnt` out 3: one-hot grant, high for the whole access.
- `ack` out 3: one-hot completion pulse, one cycle.
- `rdata` out 8: read data captured at completion; valid while `ack` is high, held until next completion.
- `busy` out 1: high while an access is in progress.
- `mem_read`, `mem_write` out 1 each: memory strobes.
- `mem_addr` out 16, `mem_wdata` out 8: registered address and write data.
- `mem_rdata` in 8: memory read data.

## Operation
- States: IDLE, ACCESS.
- Reset values: state IDLE; `gnt`, `ack`, `busy`, `mem_read`, `mem_write` 0; `mem_addr` 0; `mem_wdata` 0; `rdata` 0; wait counter 0; last-winner pointer 2, so requester 0 has first priority.
- IDLE: form the eligible set = `req` & ~`ack`, so a requester whose ack is high this cycle is ignored.
  - If the eligible set is empty, remain in IDLE.
  - Otherwise pick the first eligible index searching last_winner+1, +2, +3 (mod 3).
  - Register that requester's addr/wdata/we into `mem_addr`/`mem_wdata`.
  - Assert `mem_write` if we = 1, else `mem_read`; set `gnt[i]` and `busy`; counter = `WAIT_STATES`; last_winner = i; go to ACCESS.
- ACCESS, counter ≠ 0: decrement the counter; outputs unchanged.
- ACCESS, counter = 0:
  - Drop `mem_read`/`mem_write`, `gnt` and `busy`; pulse `ack[i]`.
  - On a read, load `rdata` ← `mem_rdata`; on a write, `rdata` is unchanged.
  - Go to IDLE.
- `ack` is cleared on every edge where it is not being set, so it is always a single-cycle pulse.
- Request inputs are sampled only at the grant edge. Changing or dropping `req`/addr/data during ACCESS has no effect, and the transaction still completes and acks.
- `mem_read` and `mem_write` are never high together. At most one `gnt` bit and one `ack` bit is high at any time.
- `mem_addr`/`mem_wdata` hold their last value in IDLE.

## Timing
- Grant latency: `req` high before edge k with the bus idle gives `gnt` and the strobe after edge k.
- Strobe width: `WAIT_STATES`+1 cycles. Completion edge = k+`WAIT_STATES`+1; `ack` and `rdata` are valid the cycle after it.
- Earliest next grant: the edge after the ack cycle. Per-access period = `WAIT_STATES`+2 cycles (3 at default).
- Requester rule: hold `req` until `ack`. Drop it on the edge after `ack`, or keep it high to request again; re-request takes effect one arbitration later.
- Simultaneous requests: resolved only by the round-robin order above; no starvation. Each requester waits at most 2 other accesses.
- Reset during ACCESS: strobes, `gnt` and `busy` fall asynchronously. No `ack` is issued and the access is lost; the pointer returns to 2.
- `WAIT_STATES` = 0: single-cycle strobe, period 2 cycles.

## Test plan
- Single CPU read, `WAIT_STATES`=1, addr 0x1234, `mem_rdata`=0xA5:
  - `gnt`=001 and `mem_read`=1 for exactly 2 cycles with `mem_addr`=0x1234.
  - `ack`=001 for 1 cycle with `rdata`=0xA5.
- DMA write, addr 0x8000, data 0x3C:
  - `mem_write`=1 for 2 cycles, `mem_wdata`=0x3C, `mem_read` never high, `ack`=010.
  - `rdata` unchanged from its prior value.
- All three `req` held high from reset for 9 accesses:
  - Grant order 0,1,2,0,1,2,0,1,2; accesses every 3 cycles.
  - Never two `gnt` bits high; each `ack` one cycle.
- CPU drops `req` and changes addr 0x0010→0xFFFF one cycle after grant:
  - Access completes at 0x0010 and `ack`=001 still pulses.
  - No further grant to requester 0.
- `reset` asserted mid-ACCESS (counter 1):
  - Strobes, `gnt`, `busy` go 0 without a clock edge; no `ack`.
  - After release with `req`=111, first grant goes to requester 0.
- `WAIT_STATES`=0, CPU holds `req` continuously:
  - Strobe width 1 cycle, `ack` every 2 cycles.
  - `req` is ignored during the `ack` cycle, so there is no double grant.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - three-way round-robin memory port arbiter and access sequencer
module mem_bus_arbiter #(
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [2:0]  req_we,
  input  logic [47:0] req_addr,
  input  logic [23:0] req_wdata,
  output logic [2:0]  gnt,
  output logic [2:0]  ack,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam logic [2:0] LP_WAIT = 3'(WAIT_STATES);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [1:0]  r_last;

  logic [2:0]  w_elig;
  logic        w_found;
  logic [1:0]  w_pick;
  logic [2:0]  w_pick_onehot;
  logic [15:0] w_addr;
  logic [7:0]  w_wdata;
  logic        w_we;

  // Round-robin pick: search starts just after the last winner; a requester
  // being acked this cycle is excluded so a held req cannot double-grant.
  always_comb begin
    w_elig  = req & ~ack;
    w_found = |w_elig;
    w_pick  = 2'd0;
    case (r_last)
      2'd0: begin
        if (w_elig[1])      w_pick = 2'd1;
        else if (w_elig[2]) w_pick = 2'd2;
        else                w_pick = 2'd0;
      end
      2'd1: begin
        if (w_elig[2])      w_pick = 2'd2;
        else if (w_elig[0]) w_pick = 2'd0;
        else                w_pick = 2'd1;
      end
      default: begin
        if (w_elig[0])      w_pick = 2'd0;
        else if (w_elig[1]) w_pick = 2'd1;
        else                w_pick = 2'd2;
      end
    endcase
    w_pick_onehot = 3'b001 << w_pick;
  end

  // Select the winning requester's address, data and direction.
  always_comb begin
    w_addr  = req_addr[15:0];
    w_wdata = req_wdata[7:0];
    w_we    = req_we[0];
    case (w_pick)
      2'd1: begin
        w_addr  = req_addr[31:16];
        w_wdata = req_wdata[15:8];
        w_we    = req_we[1];
      end
      2'd2: begin
        w_addr  = req_addr[47:32];
        w_wdata = req_wdata[23:16];
        w_we    = req_we[2];
      end
      default: begin
        w_addr  = req_addr[15:0];
        w_wdata = req_wdata[7:0];
        w_we    = req_we[0];
      end
    endcase
  end

  // Sequencer: grant and register the request, hold the strobe for the wait
  // states, then pulse ack and capture read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 3'd0;
      r_last    <= 2'd2;
      gnt       <= 3'b000;
      ack       <= 3'b000;
      busy      <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
      rdata     <= 8'h00;
    end else begin
      ack <= 3'b000;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            mem_addr  <= w_addr;
            mem_wdata <= w_wdata;
            mem_write <= w_we;
            mem_read  <= ~w_we;
            gnt       <= w_pick_onehot;
            busy      <= 1'b1;
            r_cnt     <= LP_WAIT;
            r_last    <= w_pick;
            r_state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
          end else begin
            if (mem_read) begin
              rdata <= mem_rdata;
            end
            ack       <= gnt;
            gnt       <= 3'b000;
            busy      <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter at WAIT_STATES 1 and 0
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [2:0]  req       [2];
  logic [2:0]  req_we    [2];
  logic [47:0] req_addr  [2];
  logic [23:0] req_wdata [2];
  logic [7:0]  mem_rdata [2];
  logic [2:0]  gnt       [2];
  logic [2:0]  ack       [2];
  logic [7:0]  rdata     [2];
  logic        busy      [2];
  logic        mem_read  [2];
  logic        mem_write [2];
  logic [15:0] mem_addr  [2];
  logic [7:0]  mem_wdata [2];

  mem_bus_arbiter #(.WAIT_STATES(1)) u_dut_ws1 (
    .clk(clk), .reset(reset), .req(req[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .gnt(gnt[0]), .ack(ack[0]),
    .rdata(rdata[0]), .busy(busy[0]), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  mem_bus_arbiter #(.WAIT_STATES(0)) u_dut_ws0 (
    .clk(clk), .reset(reset), .req(req[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .gnt(gnt[1]), .ack(ack[1]),
    .rdata(rdata[1]), .busy(busy[1]), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  typedef struct {
    int          lane;
    int          idx;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } grant_t;

  typedef struct {
    int          lane;
    int          idx;
    logic [7:0]  rdata;
  } ack_t;

  grant_t gq[$];
  ack_t   aq[$];

  function automatic int ws_of(input int l);
    return (l == 0) ? 1 : 0;
  endfunction

  // Transaction-level reference: one access in flight per lane, lasting
  // ws+1 edges, followed by an ack cycle in which the acked requester is skipped.
  bit         m_busy  [2];
  int         m_left  [2];
  int         m_ptr   [2];
  int         m_cur   [2];
  bit         m_we    [2];
  logic [2:0] m_ack   [2];
  logic [7:0] m_rdata [2];
  logic [2:0] m_acked;
  logic [2:0] m_elig;
  int         m_pick;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int l = 0; l < 2; l++) begin
        m_busy[l]  = 1'b0;
        m_left[l]  = 0;
        m_ptr[l]   = 2;
        m_cur[l]   = 0;
        m_we[l]    = 1'b0;
        m_ack[l]   = 3'b000;
        m_rdata[l] = 8'h00;
      end
      gq.delete();
      aq.delete();
    end else begin
      for (int l = 0; l < 2; l++) begin
        m_acked  = m_ack[l];
        m_ack[l] = 3'b000;
        if (!m_busy[l]) begin
          m_elig = req[l] & ~m_acked;
          m_pick = -1;
          for (int k = 1; k <= 3; k++) begin
            if (m_pick < 0 && m_elig[(m_ptr[l] + k) % 3]) m_pick = (m_ptr[l] + k) % 3;
          end
          if (m_pick >= 0) begin
            m_ptr[l]  = m_pick;
            m_cur[l]  = m_pick;
            m_busy[l] = 1'b1;
            m_left[l] = ws_of(l);
            m_we[l]   = req_we[l][m_pick];
            gq.push_back('{l, m_pick, req_we[l][m_pick],
                           req_addr[l][16*m_pick +: 16], req_wdata[l][8*m_pick +: 8]});
          end
        end else if (m_left[l] > 0) begin
          m_left[l] = m_left[l] - 1;
        end else begin
          m_busy[l] = 1'b0;
          if (!m_we[l]) m_rdata[l] = mem_rdata[l];
          m_ack[l] = 3'b001 << m_cur[l];
          aq.push_back('{l, m_cur[l], m_rdata[l]});
        end
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input int l, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s lane%0d: got %0h expected %0h", name, l, got, exp);
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents a new grant or an ack.
  logic [2:0]  mon_prev_gnt [2];
  int          mon_width    [2];
  logic [15:0] mon_addr     [2];
  logic [7:0]  mon_rdata    [2];
  grant_t      mon_g;
  ack_t        mon_a;
  int          mon_qi;
  int          mon_left;

  always @(negedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (reset) begin
        check("reset_outputs", l,
              64'({gnt[l], ack[l], busy[l], mem_read[l], mem_write[l], rdata[l]}), 64'd0);
        mon_prev_gnt[l] = 3'b000;
        mon_width[l]    = 0;
        mon_rdata[l]    = 8'h00;
      end else begin
        if (gnt[l] != 3'b000 && mon_prev_gnt[l] == 3'b000) begin
          mon_qi = -1;
          for (int i = 0; i < gq.size(); i++) if (mon_qi < 0 && gq[i].lane == l) mon_qi = i;
          if (mon_qi < 0) begin
            check("grant_unexpected", l, 64'(gnt[l]), 64'd0);
          end else begin
            mon_g = gq[mon_qi];
            gq.delete(mon_qi);
            check("grant", l,
                  64'({gnt[l], mem_write[l], mem_read[l], mem_addr[l], mem_wdata[l]}),
                  64'({3'b001 << mon_g.idx, mon_g.we, !mon_g.we, mon_g.addr, mon_g.wdata}));
            mon_addr[l] = mon_g.addr;
          end
          mon_width[l] = 1;
        end else if (gnt[l] != 3'b000) begin
          mon_width[l] = mon_width[l] + 1;
        end
        mon_left = 0;
        for (int i = gq.size() - 1; i >= 0; i--) begin
          if (gq[i].lane == l) begin
            mon_left++;
            gq.delete(i);
          end
        end
        check("grant_missing", l, 64'(mon_left), 64'd0);
        if (gnt[l] != 3'b000) check("addr_hold", l, 64'(mem_addr[l]), 64'(mon_addr[l]));

        if (ack[l] != 3'b000) begin
          mon_qi = -1;
          for (int i = 0; i < aq.size(); i++) if (mon_qi < 0 && aq[i].lane == l) mon_qi = i;
          if (mon_qi < 0) begin
            check("ack_unexpected", l, 64'(ack[l]), 64'd0);
          end else begin
            mon_a = aq[mon_qi];
            aq.delete(mon_qi);
            check("ack", l, 64'({ack[l], rdata[l]}), 64'({3'b001 << mon_a.idx, mon_a.rdata}));
            check("strobe_width", l, 64'(mon_width[l]), 64'(ws_of(l) + 1));
            mon_rdata[l] = mon_a.rdata;
          end
        end
        mon_left = 0;
        for (int i = aq.size() - 1; i >= 0; i--) begin
          if (aq[i].lane == l) begin
            mon_left++;
            aq.delete(i);
          end
        end
        check("ack_missing", l, 64'(mon_left), 64'd0);

        check("invariants", l,
              64'({$countones(gnt[l]) <= 1, $countones(ack[l]) <= 1,
                   !(mem_read[l] && mem_write[l]), busy[l] == (gnt[l] != 3'b000),
                   (mem_read[l] || mem_write[l]) == (gnt[l] != 3'b000),
                   rdata[l] == mon_rdata[l]}),
              64'h3f);
        mon_prev_gnt[l] = gnt[l];
      end
    end
  end

  task automatic drive_idle();
    for (int l = 0; l < 2; l++) begin
      req[l]       = 3'b000;
      mem_rdata[l] = 8'($urandom);
    end
  endtask

  task automatic drive_random();
    for (int l = 0; l < 2; l++) begin
      req[l]       = 3'($urandom);
      req_we[l]    = 3'($urandom);
      req_addr[l]  = {16'($urandom), 16'($urandom), 16'($urandom)};
      req_wdata[l] = 24'($urandom);
      mem_rdata[l] = 8'($urandom);
    end
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    for (int l = 0; l < 2; l++) begin
      req[l] = 3'b000; req_we[l] = 3'b000; req_addr[l] = 48'd0;
      req_wdata[l] = 24'd0; mem_rdata[l] = 8'd0;
    end
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;

    // CPU read of 0x1234 returning 0xA5, req held a few accesses
    @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      req[l] = 3'b001; req_we[l] = 3'b000;
      req_addr[l] = 48'h0000_0000_1234; mem_rdata[l] = 8'hA5;
    end
    repeat (6) @(negedge clk);
    drive_idle();
    repeat (3) @(negedge clk);

    // DMA write 0x3C to 0x8000 while memory read data wanders
    for (int l = 0; l < 2; l++) begin
      req[l] = 3'b010; req_we[l] = 3'b010;
      req_addr[l] = 48'h0000_8000_0000; req_wdata[l] = 24'h003C00;
    end
    repeat (6) begin
      @(negedge clk);
      for (int l = 0; l < 2; l++) mem_rdata[l] = 8'($urandom);
    end
    drive_idle();
    repeat (3) @(negedge clk);

    // CPU drops req and changes address one cycle after its grant
    for (int l = 0; l < 2; l++) begin
      req[l] = 3'b001; req_we[l] = 3'b000; req_addr[l] = 48'h0000_0000_0010;
    end
    @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      req[l] = 3'b000; req_addr[l] = 48'h0000_0000_FFFF;
    end
    repeat (5) @(negedge clk);

    // reset in the middle of an access, then all three requesting
    for (int l = 0; l < 2; l++) begin
      req[l] = 3'b111; req_we[l] = 3'b010;
      req_addr[l] = 48'h2222_1111_0000; req_wdata[l] = 24'h332211;
    end
    reset_pulse();
    repeat (30) @(negedge clk);
    drive_idle();
    repeat (3) @(negedge clk);

    // random traffic with occasional asynchronous resets
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      drive_random();
      if ($urandom_range(0, 249) == 0) reset_pulse();
    end
    @(negedge clk);
    drive_idle();
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
